flash_bus_ctrl: RTL
===================

FLASH_BUS_CTRL -- requirements
Module: flash_bus_ctrl

Interface
REQ-001 SHALL have parameter PULSE_CYC, default 5, meaning WE#/OE# active width in clocks (legal range 2..15).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 2500000, meaning program-busy limit in clocks (used only with FLASH_TIMEOUT_EN).
REQ-003 SHALL have port CLK_50MHZ  in  1  system clock; the block has one clock, and reset is synchronous and active-low.
REQ-004 SHALL have port RST  in  1  synchronous active-low reset, sampled on the CLK_50MHZ rising edge; 0 = reset.
REQ-005 SHALL have port fb_start  in  1  one-cycle request pulse from the flash manager.
REQ-006 SHALL have port FL_FLOW  in  1  access direction, sampled with fb_start: 1 = program (write), 0 = read.
REQ-007 SHALL have port FL_ADDR  in  8  flash byte address, sampled with fb_start.
REQ-008 SHALL have port FL_DATA  inout  8  manager-side data: write data in; read data out during the present window only.
REQ-009 SHALL have port fb_done  out  1  one-cycle completion pulse.
REQ-010 SHALL have port fb_err  out  1  error flag, valid while fb_done=1.
REQ-011 SHALL have port SF_A  out  24  flash address: SF_A[7:0] = latched address, SF_A[23:8] = 0.
REQ-012 SHALL have port SF_D  inout  8  flash data bus.
REQ-013 SHALL have ports SF_CE0, SF_OE, SF_WE  out  1 each  active-low flash strobes.
REQ-014 SHALL have port SF_STS  in  1  flash ready/busy: 1 = ready.

Function
REQ-015 SHALL implement the states IDLE, CMD_SETUP, CMD_PULSE, CMD_HOLD, RD_ACC, PG_SETUP, PG_PULSE, PG_HOLD, PG_BUSY, DONE, PRESENT.
REQ-016 In IDLE, fb_start=1 SHALL latch FL_FLOW, FL_ADDR and FL_DATA into internal registers and move to CMD_SETUP; fb_start in any other state SHALL be ignored.
REQ-017 CMD_SETUP (1 clk) SHALL drive SF_CE0=0 and SF_D = 0xFF for a read or 0x40 for a program; CMD_PULSE SHALL hold SF_WE=0 for PULSE_CYC clks; CMD_HOLD (1 clk) SHALL keep SF_D driven with SF_WE=1.
REQ-018 For a read, RD_ACC SHALL release SF_D, hold SF_OE=0 for PULSE_CYC clks, capture SF_D into rd_buf on the last clk, then go to DONE.
REQ-019 For a program, PG_SETUP/PG_PULSE/PG_HOLD SHALL repeat the REQ-017 timing with SF_D = latched write data, then enter PG_BUSY.
REQ-020 PG_BUSY SHALL deassert CE0/OE/WE, wait 2 clks, then wait for SF_STS=1 before going to DONE.
REQ-021 DONE SHALL pulse fb_done=1 for exactly 1 clk and raise SF_CE0 high; the next state SHALL be PRESENT for a read and IDLE for a program.
REQ-022 PRESENT (1 clk) SHALL drive FL_DATA = rd_buf; FL_DATA SHALL be hi-Z in all other states.
REQ-023 SF_D SHALL be driven only in the CMD_*/PG_SETUP/PG_PULSE/PG_HOLD states; SF_OE=0 and SF_WE=0 SHALL never be asserted together.
REQ-024 SF_A SHALL hold the latched address from CMD_SETUP through DONE and SHALL be 0 in IDLE.
REQ-025 Read latency from fb_start to fb_done SHALL be 2*PULSE_CYC+4 clks; program latency SHALL be 2*PULSE_CYC+9+busy clks, where busy = the number of clks SF_STS is low after the PG_BUSY 2-clk guard.
REQ-026 The pulse counter SHALL be 4 bits, load PULSE_CYC-1 and count down to 0; it SHALL not wrap.

Reset
REQ-027 While RST=0, the block SHALL enter IDLE with SF_CE0=SF_OE=SF_WE=1, SF_D and FL_DATA hi-Z, SF_A=0, fb_done=0, fb_err=0, rd_buf=0 and all counters at 0.
REQ-028 Reset asserted mid-access SHALL abort the access within 1 clk with no fb_done; reset SHALL override a simultaneous fb_start.

Configuration
REQ-029 With FLASH_TIMEOUT_EN defined, a 22-bit counter SHALL run in PG_BUSY; reaching TIMEOUT_CYC SHALL go to DONE with fb_err=1 and return to IDLE.
REQ-030 Without FLASH_TIMEOUT_EN, PG_BUSY SHALL wait indefinitely, fb_err SHALL be tied 0, and no timeout counter SHALL exist.

Verification
REQ-031 Read test: flash model holds 0x5A at address 0x12; FL_FLOW=0, FL_ADDR=0x12, fb_start -> SF_D=0xFF write, then OE pulse, fb_done at +14 clks, FL_DATA=0x5A for 1 clk.
REQ-032 Program test: FL_FLOW=1, FL_ADDR=0x34, FL_DATA=0xA7, SF_STS low 10 clks -> WE pulses with 0x40 then 0xA7, fb_done at +29 clks with fb_err=0.
REQ-033 Busy-ignore test: a second fb_start 3 clks after the first -> exactly one access and one fb_done.
REQ-034 Reset test: RST=0 during PG_PULSE -> next clk strobes high, SF_D hi-Z, no fb_done; a following read completes normally.
REQ-035 Timeout test (FLASH_TIMEOUT_EN, TIMEOUT_CYC=100): SF_STS held 0 -> fb_done with fb_err=1 after 100 clks in PG_BUSY; without the macro, no fb_done.
REQ-036 Checker on all tests: SF_OE=0 and SF_WE=0 never asserted together; FL_DATA driven only in PRESENT.

Source files
------------

// File: rtl/flash_bus_ctrl.sv
// rtl/flash_bus_ctrl.sv - single-byte parallel NOR flash bus sequencer
//
// Purpose: runs one flash access per fb_start pulse. A read writes the 0xFF
// read-array command, then pulses OE# and captures the byte; the byte is shown
// on FL_DATA for one clock after fb_done. A program writes the 0x40 setup
// command followed by the data byte, then waits for SF_STS to report ready.
//
// Ports:
//   CLK_50MHZ, RST        clock, synchronous active-low reset
//   fb_start              one-cycle request pulse (ignored while busy)
//   FL_FLOW, FL_ADDR      direction (1 = program) and byte address, sampled with fb_start
//   FL_DATA               write data in with fb_start; read data out in PRESENT only
//   fb_done, fb_err       one-cycle completion pulse and its error flag
//   SF_A, SF_D            flash address and bidirectional data bus
//   SF_CE0, SF_OE, SF_WE  active-low flash strobes
//   SF_STS                flash ready/busy, 1 = ready
//
// Configuration: define FLASH_TIMEOUT_EN to bound the program-busy wait to
// TIMEOUT_CYC clocks; the access then completes with fb_err=1.

module flash_bus_ctrl #(
   parameter int unsigned PULSE_CYC   = 5,
   parameter int unsigned TIMEOUT_CYC = 2500000
) (
   input  logic        CLK_50MHZ,
   input  logic        RST,
   input  logic        fb_start,
   input  logic        FL_FLOW,
   input  logic [7:0]  FL_ADDR,
   inout  wire  [7:0]  FL_DATA,
   output logic        fb_done,
   output logic        fb_err,
   output logic [23:0] SF_A,
   inout  wire  [7:0]  SF_D,
   output logic        SF_CE0,
   output logic        SF_OE,
   output logic        SF_WE,
   input  logic        SF_STS
);

   if (PULSE_CYC < 2 || PULSE_CYC > 15 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 4194303) begin : g_param_check
      $error("flash_bus_ctrl: PULSE_CYC or TIMEOUT_CYC out of range");
   end

   typedef enum logic [3:0] {
      IDLE, CMD_SETUP, CMD_PULSE, CMD_HOLD, RD_ACC,
      PG_SETUP, PG_PULSE, PG_HOLD, PG_BUSY, DONE, PRESENT
   } state_t;

   localparam logic [3:0] CNT_LOAD   = 4'(PULSE_CYC - 1);
   // Two guard clocks in PG_BUSY before SF_STS is trusted: the device may not
   // have pulled STS low yet right after the data WE# pulse.
   localparam logic [3:0] GUARD_LOAD = 4'd2;
   localparam logic [7:0] CMD_READ   = 8'hFF;
   localparam logic [7:0] CMD_PROG   = 8'h40;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        flow_q, flow_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  rd_buf_q, rd_buf_d;

`ifdef FLASH_TIMEOUT_EN
   localparam logic [21:0] TO_LAST = 22'(TIMEOUT_CYC - 1);
   logic [21:0] to_cnt_q, to_cnt_d;
   logic        err_q, err_d;
`endif

   logic        sd_en;
   logic [7:0]  sd_val;
   logic        a_en;

   always_ff @(posedge CLK_50MHZ) begin
      if (!RST) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         flow_q   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rd_buf_q <= '0;
`ifdef FLASH_TIMEOUT_EN
         to_cnt_q <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         flow_q   <= flow_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rd_buf_q <= rd_buf_d;
`ifdef FLASH_TIMEOUT_EN
         to_cnt_q <= to_cnt_d;
         err_q    <= err_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      flow_d   = flow_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rd_buf_d = rd_buf_q;
`ifdef FLASH_TIMEOUT_EN
      to_cnt_d = to_cnt_q;
      err_d    = err_q;
`endif
      case (state_q)
         IDLE: begin
`ifdef FLASH_TIMEOUT_EN
            err_d = 1'b0;
`endif
            if (fb_start) begin
               flow_d  = FL_FLOW;
               addr_d  = FL_ADDR;
               wdata_d = FL_DATA;
               state_d = CMD_SETUP;
            end
         end
         CMD_SETUP: begin
            state_d = CMD_PULSE;
            cnt_d   = CNT_LOAD;
         end
         CMD_PULSE: begin
            if (cnt_q == 4'd0) state_d = CMD_HOLD;
            else               cnt_d   = cnt_q - 4'd1;
         end
         CMD_HOLD: begin
            if (flow_q) begin
               state_d = PG_SETUP;
            end else begin
               state_d = RD_ACC;
               cnt_d   = CNT_LOAD;
            end
         end
         RD_ACC: begin
            if (cnt_q == 4'd0) begin
               rd_buf_d = SF_D;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         PG_SETUP: begin
            state_d = PG_PULSE;
            cnt_d   = CNT_LOAD;
         end
         PG_PULSE: begin
            if (cnt_q == 4'd0) state_d = PG_HOLD;
            else               cnt_d   = cnt_q - 4'd1;
         end
         PG_HOLD: begin
            state_d = PG_BUSY;
            cnt_d   = GUARD_LOAD;
         end
         PG_BUSY: begin
            if (cnt_q != 4'd0) cnt_d   = cnt_q - 4'd1;
            else if (SF_STS)   state_d = DONE;
`ifdef FLASH_TIMEOUT_EN
            to_cnt_d = to_cnt_q + 22'd1;
            // A ready seen in the same clock as the limit still counts as success.
            if (state_d != DONE && to_cnt_q == TO_LAST) begin
               state_d = DONE;
               err_d   = 1'b1;
               cnt_d   = 4'd0;
            end
            if (state_d == DONE) to_cnt_d = '0;
`endif
         end
         DONE: begin
            state_d = flow_q ? IDLE : PRESENT;
         end
         PRESENT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      SF_CE0  = 1'b1;
      SF_OE   = 1'b1;
      SF_WE   = 1'b1;
      sd_en   = 1'b0;
      sd_val  = 8'h00;
      a_en    = 1'b0;
      fb_done = 1'b0;
      case (state_q)
         CMD_SETUP, CMD_HOLD: begin
            SF_CE0 = 1'b0;
            sd_en  = 1'b1;
            sd_val = flow_q ? CMD_PROG : CMD_READ;
            a_en   = 1'b1;
         end
         CMD_PULSE: begin
            SF_CE0 = 1'b0;
            SF_WE  = 1'b0;
            sd_en  = 1'b1;
            sd_val = flow_q ? CMD_PROG : CMD_READ;
            a_en   = 1'b1;
         end
         RD_ACC: begin
            SF_CE0 = 1'b0;
            SF_OE  = 1'b0;
            a_en   = 1'b1;
         end
         PG_SETUP, PG_HOLD: begin
            SF_CE0 = 1'b0;
            sd_en  = 1'b1;
            sd_val = wdata_q;
            a_en   = 1'b1;
         end
         PG_PULSE: begin
            SF_CE0 = 1'b0;
            SF_WE  = 1'b0;
            sd_en  = 1'b1;
            sd_val = wdata_q;
            a_en   = 1'b1;
         end
         PG_BUSY: begin
            a_en = 1'b1;
         end
         DONE: begin
            a_en    = 1'b1;
            fb_done = 1'b1;
         end
         default: begin
         end
      endcase
   end

`ifdef FLASH_TIMEOUT_EN
   assign fb_err = (state_q == DONE) & err_q;
`else
   assign fb_err = 1'b0;
`endif

   assign SF_A    = a_en ? {16'h0000, addr_q} : 24'h000000;
   assign SF_D    = sd_en ? sd_val : 8'hzz;
   assign FL_DATA = (state_q == PRESENT) ? rd_buf_q : 8'hzz;

endmodule
